// File: rtl/quantize_sequencer_if.sv
// Bus between the accumulator drain and the SRAM write-out stage of the quantize sequencer.
// master drives the accumulator side; slave is the sequencer itself.
interface quantize_sequencer_if #(
  parameter int ARRAY_SIZE        = 8,
  parameter int ACC_WIDTH         = 32,
  parameter int OUTPUT_DATA_WIDTH = 16
);
  logic                                    start;
  logic [1:0]                              data_set_in;
  logic                                    acc_valid;
  logic [ARRAY_SIZE*ACC_WIDTH-1:0]         acc_data;
  logic                                    sram_write_enable;
  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data;
  logic [5:0]                              matrix_index;
  logic [1:0]                              data_set;
  logic                                    busy;
  logic                                    done;

  modport master (
    output start, data_set_in, acc_valid, acc_data,
    input  sram_write_enable, quantized_data, matrix_index, data_set, busy, done
  );

  modport slave (
    input  start, data_set_in, acc_valid, acc_data,
    output sram_write_enable, quantized_data, matrix_index, data_set, busy, done
  );
endinterface

// File: rtl/quantize_sequencer.sv
// Sequences one output tile of 2N-1 accumulator diagonals, quantizing each lane
// (round half up, shift, saturate) into a registered SRAM write.
module quantize_sequencer #(
  parameter int ARRAY_SIZE        = 8,
  parameter int ACC_WIDTH         = 32,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int SHIFT             = 8
) (
  input  logic                 clk,
  input  logic                 srstn,
  quantize_sequencer_if.slave  bus
);
  localparam int W = OUTPUT_DATA_WIDTH;
  localparam logic [5:0] LAST_INDEX = 6'(2 * ARRAY_SIZE - 2);
  localparam logic signed [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] MAX_VAL =
    {{(ACC_WIDTH + 2 - W){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_VAL = ~MAX_VAL;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [5:0]               cnt_q, cnt_d;
  logic [1:0]               set_q, set_d;
  logic                     we_q, we_d;
  logic [5:0]               idx_q, idx_d;
  logic [ARRAY_SIZE*W-1:0]  qdata_q, qdata_d;
  logic [ARRAY_SIZE*W-1:0]  q_lanes;

  // One extra headroom bit keeps the rounding add from overflowing before the shift.
  function automatic logic [W-1:0] quantize_lane(input logic [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] rounded;
    ext     = signed'({acc[ACC_WIDTH-1], acc});
    rounded = (ext + HALF) >>> SHIFT;
    if (rounded > MAX_VAL) begin
      return MAX_VAL[W-1:0];
    end else if (rounded < MIN_VAL) begin
      return MIN_VAL[W-1:0];
    end else begin
      return rounded[W-1:0];
    end
  endfunction

  always_comb begin
    q_lanes = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      q_lanes[i*W +: W] = quantize_lane(bus.acc_data[i*ACC_WIDTH +: ACC_WIDTH]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    we_d    = 1'b0;
    idx_d   = '0;
    qdata_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          set_d   = bus.data_set_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.acc_valid) begin
          we_d    = 1'b1;
          idx_d   = cnt_q;
          qdata_d = q_lanes;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == LAST_INDEX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      set_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      qdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      qdata_q <= qdata_d;
    end
  end

  assign bus.sram_write_enable = we_q;
  assign bus.matrix_index      = idx_q;
  assign bus.quantized_data    = qdata_q;
  assign bus.data_set          = set_q;
  assign bus.busy              = (state_q == RUN);
  assign bus.done              = (state_q == DONE);
endmodule

// File: doc/quantize_sequencer.md
QUANTIZE_SEQUENCER -- requirements
Module: quantize_sequencer

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8: systolic array dimension N; legal range 2..32 so that 2N-2 fits in matrix_index.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: signed accumulator width per lane.
REQ-003 SHALL have parameter OUTPUT_DATA_WIDTH, default 16: signed quantized width per lane (W).
REQ-004 SHALL have parameter SHIFT, default 8: fractional bits removed by quantization; legal range 1..ACC_WIDTH-1.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port srstn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: single-cycle request to begin one output tile.
REQ-008 SHALL have port data_set_in, input, 2: tile data set, sampled only when start is accepted.
REQ-009 SHALL have port acc_valid, input, 1: acc_data carries one diagonal this cycle.
REQ-010 SHALL have port acc_data, input, ARRAY_SIZE*ACC_WIDTH: signed accumulators; lane i at bits [i*ACC_WIDTH +: ACC_WIDTH].
REQ-011 SHALL have port sram_write_enable, output, 1: registered; quantized_data/matrix_index/data_set valid this cycle.
REQ-012 SHALL have port quantized_data, output, ARRAY_SIZE*W: registered; lane i at bits [i*W +: W].
REQ-013 SHALL have port matrix_index, output, 6: registered diagonal index, 0..2N-2.
REQ-014 SHALL have port data_set, output, 2: registered latched data set.
REQ-015 SHALL have port busy, output, 1: high while state is RUN.
REQ-016 SHALL have port done, output, 1: one-cycle pulse while state is DONE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 In IDLE, start=1 SHALL latch data_set_in, clear the beat counter to 0 and go to RUN; start in RUN or DONE SHALL be ignored.
REQ-019 In RUN, each cycle with acc_valid=1 SHALL be one accepted beat; acc_valid outside RUN SHALL be ignored.
REQ-020 A beat accepted at cycle t SHALL produce, at t+1: sram_write_enable=1, matrix_index=beat counter value at t, data_set=latched value, quantized_data=quantized acc_data from t.
REQ-021 The beat counter SHALL increment by 1 per accepted beat only; acc_valid=0 cycles SHALL stall the sequence with no write.
REQ-022 The beat with counter 2N-2 SHALL move RUN->DONE; DONE SHALL last exactly one cycle and return to IDLE unconditionally.
REQ-023 done SHALL coincide with the write of matrix_index 2N-2; busy SHALL be 0 in that cycle.
REQ-024 Cycles with no accepted beat SHALL drive sram_write_enable=0, quantized_data=0, matrix_index=0; data_set SHALL hold its last latched value.
REQ-025 Each lane SHALL be quantized as follows:
- sign-extend to ACC_WIDTH+1 bits;
- add 2^(SHIFT-1) (round half toward +inf);
- arithmetic right shift by SHIFT;
- saturate to [-2^(W-1), 2^(W-1)-1].
REQ-026 Lanes SHALL be quantized independently with no lane reordering; write_out performs diagonal alignment and masking.
REQ-027 Any data_set_in value (0..3) SHALL be accepted and passed through unchanged; changes to data_set_in during RUN SHALL have no effect.

Reset
REQ-028 srstn=0 SHALL, asynchronously and immediately, force IDLE, beat counter 0, and sram_write_enable=0, quantized_data=0, matrix_index=0, data_set=0, busy=0, done=0.
REQ-029 Reset asserted mid-RUN SHALL abandon the tile with no further writes; the first start after release SHALL restart at matrix_index 0.

Verification (N=8, ACC_WIDTH=32, W=16, SHIFT=8)
REQ-030 Full tile: start with data_set_in=0, then acc_valid=1 for 15 cycles -> 15 consecutive writes with matrix_index 0..14, done=1 only with index 14, busy high for exactly 15 cycles.
REQ-031 Rounding: lane0 inputs 384, 383, -384, -385 -> outputs 2, 1, -1, -2 (0x0002, 0x0001, 0xFFFF, 0xFFFE).
REQ-032 Saturation: inputs 0x7FFFFFFF, 0x00800000, 0x80000000 -> outputs 0x7FFF, 0x7FFF, 0x8000.
REQ-033 Stall and latch: data_set_in=1 at start, changed to 2 mid-run; acc_valid pattern 1,0,0,1 -> writes only in the cycles after each 1, indices 0 then 1, data_set stays 1.
REQ-034 Control corners: start during RUN and during DONE -> ignored; start on the cycle after DONE -> accepted, counter at 0.
REQ-035 Reset mid-run: srstn=0 at matrix_index 5 -> all outputs 0 in the same cycle with no clock edge required; after release, no writes until the next start.
